// File: rtl/pq_pkg.sv
// rtl/pq_pkg.sv - shared widths, entry type and state/operation enums for the QuickQ storage node
package pq_pkg;

  localparam int PQ_KEY_W = 16;
  localparam int PQ_VAL_W = 16;
  localparam int PQ_DEPTH = 8;

  typedef struct packed {
    logic [PQ_KEY_W-1:0] key;
    logic [PQ_VAL_W-1:0] val;
  } pq_entry_t;

  typedef enum logic {
    IDLE,
    WAIT
  } pq_node_state_t;

  // Single operation selected per cycle by the control process
  typedef enum logic [2:0] {
    OP_NONE,
    OP_WRITE,
    OP_READ,
    OP_REPLACE,
    OP_REFILL
  } pq_op_t;

  // Occupancy counter width for a node of the given depth
  function automatic int pq_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pq_insert_pos.sv
// rtl/pq_insert_pos.sv - parallel compare giving the sorted insert slot and evict-new flag
module pq_insert_pos
  import pq_pkg::*;
#(
  parameter int KEY_W = PQ_KEY_W,
  parameter int DEPTH = PQ_DEPTH
) (
  input  logic [DEPTH-1:0][KEY_W-1:0]  keys,
  input  logic [$clog2(DEPTH+1)-1:0]   count,
  input  logic [KEY_W-1:0]             key,
  output logic [$clog2(DEPTH+1)-1:0]   pos,
  output logic                         evict_new
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  // Keys are sorted, so counting valid keys <= key lands after the last equal key (FIFO ties)
  always_comb begin
    pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((i < int'(count)) && (keys[i] <= key)) begin
        pos = pos + CNT_W'(1);
      end
    end
  end

  // A slot past the tail can only be reached when full and key >= tail key
  assign evict_new = (pos == CNT_W'(DEPTH));

endmodule

// File: rtl/pq_storage_node.sv
// rtl/pq_storage_node.sv - one sorted QuickQ level with eviction and refill; optional err_o under PQ_NODE_ERR_EN
module pq_storage_node
  import pq_pkg::*;
#(
  parameter int KEY_W = PQ_KEY_W,
  parameter int VAL_W = PQ_VAL_W,
  parameter int DEPTH = PQ_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset_i,
  input  logic                         write_i,
  input  logic                         read_i,
  input  logic [KEY_W-1:0]             key_i,
  input  logic [VAL_W-1:0]             val_i,
  output logic [KEY_W-1:0]             min_key_o,
  output logic [VAL_W-1:0]             min_val_o,
  output logic                         min_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         busy_o,
  output logic                         ovf_write_o,
  output logic [KEY_W-1:0]             ovf_key_o,
  output logic [VAL_W-1:0]             ovf_val_o,
`ifdef PQ_NODE_ERR_EN
  output logic                         err_o,
`endif
  input  logic                         ds_empty_i,
  output logic                         refill_read_o,
  input  logic                         refill_ack_i,
  input  logic [KEY_W-1:0]             refill_key_i,
  input  logic [VAL_W-1:0]             refill_val_i
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  pq_node_state_t state_q, state_n;
  pq_op_t         op;

  logic [DEPTH-1:0][KEY_W-1:0] key_q, key_n, key_dn, key_up;
  logic [DEPTH-1:0][VAL_W-1:0] val_q, val_n, val_dn, val_up;
  logic [CNT_W-1:0]            cnt_q, cnt_n;
  logic [CNT_W-1:0]            ins_pos, rep_pos;
  logic                        evict_new;
  logic                        full, empty;
  logic                        ovf_n;
  logic [KEY_W-1:0]            ovf_key_n;
  logic [VAL_W-1:0]            ovf_val_n;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  pq_insert_pos #(
    .KEY_W (KEY_W),
    .DEPTH (DEPTH)
  ) u_insert_pos (
    .keys      (key_q),
    .count     (cnt_q),
    .key       (key_i),
    .pos       (ins_pos),
    .evict_new (evict_new)
  );

  // With the head removed first, every slot moves down one unless key_i sorts before the head
  assign rep_pos = (ins_pos == '0) ? '0 : ins_pos - CNT_W'(1);

  // Shift-down and shift-up views of the storage array
  always_comb begin
    key_dn = '0;
    val_dn = '0;
    key_up = '0;
    val_up = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      key_dn[i]   = key_q[i+1];
      val_dn[i]   = val_q[i+1];
      key_up[i+1] = key_q[i];
      val_up[i+1] = val_q[i];
    end
  end

  // Control: choose this cycle's operation, next state and the refill pop strobe
  always_comb begin
    state_n       = state_q;
    op            = OP_NONE;
    refill_read_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (write_i) begin
          op = (read_i && !empty) ? OP_REPLACE : OP_WRITE;
        end else if (read_i && !empty) begin
          op = OP_READ;
          if (full && !ds_empty_i) begin
            refill_read_o = 1'b1;
            state_n       = WAIT;
          end
        end
      end
      WAIT: begin
        if (refill_ack_i) begin
          op      = OP_REFILL;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: next storage contents, occupancy and eviction for the chosen operation
  always_comb begin
    key_n     = key_q;
    val_n     = val_q;
    cnt_n     = cnt_q;
    ovf_n     = 1'b0;
    ovf_key_n = ovf_key_o;
    ovf_val_n = ovf_val_o;
    case (op)
      OP_WRITE: begin
        if (full && evict_new) begin
          ovf_n     = 1'b1;
          ovf_key_n = key_i;
          ovf_val_n = val_i;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(ins_pos)) begin
              key_n[i] = key_i;
              val_n[i] = val_i;
            end else if (i > int'(ins_pos)) begin
              key_n[i] = key_up[i];
              val_n[i] = val_up[i];
            end
          end
          if (full) begin
            ovf_n     = 1'b1;
            ovf_key_n = key_q[DEPTH-1];
            ovf_val_n = val_q[DEPTH-1];
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
      end
      OP_READ: begin
        key_n = key_dn;
        val_n = val_dn;
        cnt_n = cnt_q - CNT_W'(1);
      end
      OP_REPLACE: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i < int'(rep_pos)) begin
            key_n[i] = key_dn[i];
            val_n[i] = val_dn[i];
          end else if (i == int'(rep_pos)) begin
            key_n[i] = key_i;
            val_n[i] = val_i;
          end
        end
      end
      OP_REFILL: begin
        key_n[DEPTH-1] = refill_key_i;
        val_n[DEPTH-1] = refill_val_i;
        cnt_n          = FULL_CNT;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Storage, occupancy, registered head and overflow outputs
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      key_q       <= '0;
      val_q       <= '0;
      cnt_q       <= '0;
      min_key_o   <= '0;
      min_val_o   <= '0;
      ovf_write_o <= 1'b0;
      ovf_key_o   <= '0;
      ovf_val_o   <= '0;
    end else begin
      key_q       <= key_n;
      val_q       <= val_n;
      cnt_q       <= cnt_n;
      min_key_o   <= (cnt_n != '0) ? key_n[0] : '0;
      min_val_o   <= (cnt_n != '0) ? val_n[0] : '0;
      ovf_write_o <= ovf_n;
      ovf_key_o   <= ovf_key_n;
      ovf_val_o   <= ovf_val_n;
    end
  end

  assign count_o     = cnt_q;
  assign full_o      = full;
  assign min_valid_o = !empty;
  assign busy_o      = (state_q == WAIT);

`ifdef PQ_NODE_ERR_EN
  logic err_set;

  assign err_set = ((state_q == IDLE) && read_i && !write_i && empty) ||
                   ((state_q == WAIT) && (read_i || write_i)) ||
                   ((state_q == IDLE) && refill_ack_i);

  // Sticky protocol error flag, cleared only by reset
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      err_o <= 1'b0;
    end else begin
      err_o <= err_o | err_set;
    end
  end
`endif

endmodule

// File: tb/tb_pq_storage_node.sv
// tb/tb_pq_storage_node.sv - scoreboard bench for pq_storage_node at DEPTH=4
module tb_pq_storage_node;

  localparam int KW    = 16;
  localparam int VW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          write_i = 1'b0;
  logic          read_i = 1'b0;
  logic [KW-1:0] key_i = '0;
  logic [VW-1:0] val_i = '0;
  logic [KW-1:0] min_key_o;
  logic [VW-1:0] min_val_o;
  logic          min_valid_o;
  logic [CW-1:0] count_o;
  logic          full_o;
  logic          busy_o;
  logic          ovf_write_o;
  logic [KW-1:0] ovf_key_o;
  logic [VW-1:0] ovf_val_o;
  logic          ds_empty_i = 1'b1;
  logic          refill_read_o;
  logic          refill_ack_i = 1'b0;
  logic [KW-1:0] refill_key_i = '0;
  logic [VW-1:0] refill_val_i = '0;
`ifdef PQ_NODE_ERR_EN
  logic          err_o;
`endif

  always #5 clk = ~clk;

  pq_storage_node #(
    .KEY_W (KW),
    .VAL_W (VW),
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .write_i       (write_i),
    .read_i        (read_i),
    .key_i         (key_i),
    .val_i         (val_i),
    .min_key_o     (min_key_o),
    .min_val_o     (min_val_o),
    .min_valid_o   (min_valid_o),
    .count_o       (count_o),
    .full_o        (full_o),
    .busy_o        (busy_o),
    .ovf_write_o   (ovf_write_o),
    .ovf_key_o     (ovf_key_o),
    .ovf_val_o     (ovf_val_o),
`ifdef PQ_NODE_ERR_EN
    .err_o         (err_o),
`endif
    .ds_empty_i    (ds_empty_i),
    .refill_read_o (refill_read_o),
    .refill_ack_i  (refill_ack_i),
    .refill_key_i  (refill_key_i),
    .refill_val_i  (refill_val_i)
  );

  typedef struct {
    int unsigned key;
    int unsigned val;
  } ent_t;

  typedef struct {
    int unsigned key;
    int unsigned val;
    int unsigned cnt;
    bit          busy;
  } snap_t;

  ent_t  mdl[$];
  ent_t  ovf_q[$];
  snap_t exp_q[$];
  bit    m_busy = 1'b0;
  bit    m_err = 1'b0;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void mdl_insert(input ent_t e);
    int  idx = mdl.size();
    bit  found = 1'b0;
    for (int i = 0; i < mdl.size(); i++) begin
      if (!found && mdl[i].key > e.key) begin
        idx   = i;
        found = 1'b1;
      end
    end
    mdl.insert(idx, e);
  endfunction

  // One clock of stimulus: update the model, push expectations, clock, then pop and compare
  task automatic do_cycle(input bit w, input bit r, input int unsigned k, input int unsigned v,
                          input bit ds_empty, input bit ack, input int unsigned rk);
    bit    exp_rd = 1'b0;
    bit    exp_ovf;
    snap_t s;
    ent_t  e;
    ent_t  t;
    write_i      = w;
    read_i       = r;
    key_i        = KW'(k);
    val_i        = VW'(v);
    ds_empty_i   = ds_empty;
    refill_ack_i = ack;
    refill_key_i = KW'(rk);
    refill_val_i = VW'(rk + 100);
    e.key = k;
    e.val = v;
    if (m_busy) begin
      if (r || w) m_err = 1'b1;
      if (ack) begin
        t.key = rk;
        t.val = rk + 100;
        mdl.push_back(t);
        m_busy = 1'b0;
      end
    end else begin
      if (ack) m_err = 1'b1;
      if (w) begin
        if (r && mdl.size() > 0) begin
          void'(mdl.pop_front());
          mdl_insert(e);
        end else if (mdl.size() == DEPTH) begin
          if (k >= mdl[DEPTH-1].key) begin
            ovf_q.push_back(e);
          end else begin
            ovf_q.push_back(mdl.pop_back());
            mdl_insert(e);
          end
        end else begin
          mdl_insert(e);
        end
      end else if (r) begin
        if (mdl.size() == 0) begin
          m_err = 1'b1;
        end else begin
          exp_rd = (mdl.size() == DEPTH) && !ds_empty;
          void'(mdl.pop_front());
          if (exp_rd) m_busy = 1'b1;
        end
      end
    end
    s.cnt  = mdl.size();
    s.key  = (mdl.size() > 0) ? mdl[0].key : 0;
    s.val  = (mdl.size() > 0) ? mdl[0].val : 0;
    s.busy = m_busy;
    exp_q.push_back(s);
    #1;
    check("refill_read", 32'(refill_read_o), 32'(exp_rd));
    @(posedge clk);
    #1;
    write_i      = 1'b0;
    read_i       = 1'b0;
    refill_ack_i = 1'b0;
    s = exp_q.pop_front();
    check("min_key", 32'(min_key_o), s.key);
    check("min_val", 32'(min_val_o), s.val);
    check("count", 32'(count_o), s.cnt);
    check("min_valid", 32'(min_valid_o), 32'(s.cnt != 0));
    check("full", 32'(full_o), 32'(s.cnt == DEPTH));
    check("busy", 32'(busy_o), 32'(s.busy));
    exp_ovf = (ovf_q.size() != 0);
    check("ovf_write", 32'(ovf_write_o), 32'(exp_ovf));
    if (exp_ovf) begin
      t = ovf_q.pop_front();
      if (ovf_write_o) begin
        check("ovf_key", 32'(ovf_key_o), t.key);
        check("ovf_val", 32'(ovf_val_o), t.val);
      end
    end
`ifdef PQ_NODE_ERR_EN
    check("err", 32'(err_o), 32'(m_err));
`endif
  endtask

  task automatic wr(input int unsigned k);
    do_cycle(1'b1, 1'b0, k, k + 100, 1'b1, 1'b0, 0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 0);
  endtask

  task automatic fill_1258();
    int unsigned ks[4];
    ks = '{5, 1, 8, 2};
    for (int i = 0; i < 4; i++) wr(ks[i]);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge
  task automatic async_reset();
    #2;
    reset_i = 1'b1;
    #1;
    check("rst_min_key", 32'(min_key_o), 0);
    check("rst_min_val", 32'(min_val_o), 0);
    check("rst_count", 32'(count_o), 0);
    check("rst_min_valid", 32'(min_valid_o), 0);
    check("rst_full", 32'(full_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_ovf_write", 32'(ovf_write_o), 0);
    check("rst_ovf_key", 32'(ovf_key_o), 0);
    check("rst_refill_read", 32'(refill_read_o), 0);
`ifdef PQ_NODE_ERR_EN
    check("rst_err", 32'(err_o), 0);
`endif
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    mdl.delete();
    ovf_q.delete();
    exp_q.delete();
    m_busy = 1'b0;
    m_err  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    async_reset();

    // FIFO order among equal keys
    wr(7);
    wr(3);
    wr(9);
    do_cycle(1'b1, 1'b0, 3, 203, 1'b1, 1'b0, 0);
    drain(4);
    // Read on an empty node is ignored
    drain(1);
    do_cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 0);

    // Eviction of tail and of the new entry itself
    fill_1258();
    wr(6);
    wr(10);
    do_cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 0);
    drain(4);

    // Refill from downstream with a delayed ack and an ignored write while busy
    fill_1258();
    do_cycle(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 0);
    do_cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    do_cycle(1'b1, 1'b0, 0, 100, 1'b0, 1'b0, 0);
    do_cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 12);
    drain(4);

    // Replace-min on a partly filled node and on an empty node
    wr(4);
    wr(6);
    do_cycle(1'b1, 1'b1, 5, 105, 1'b1, 1'b0, 0);
    do_cycle(1'b1, 1'b1, 2, 102, 1'b1, 1'b0, 0);
    drain(2);
    do_cycle(1'b1, 1'b1, 5, 105, 1'b1, 1'b0, 0);
    drain(1);

    // Reset while waiting for a refill, then a stray ack
    async_reset();
    fill_1258();
    do_cycle(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 0);
    async_reset();
    do_cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 33);
    do_cycle(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 0);

    // Random mix of writes, reads and replace-min with many equal keys
    for (int i = 0; i < 80; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 3);
      do_cycle(sel == 0 || sel == 2, sel == 1 || sel == 2, $urandom_range(0, 15),
               $urandom_range(0, 65535), 1'b1, 1'b0, 0);
    end
    drain(DEPTH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
